// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the multi-channel song sequencer.
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - note-word and order-word field positions and widths
package seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle    = 3'd0;
   localparam state_t StOrdAddr = 3'd1;
   localparam state_t StOrdData = 3'd2;
   localparam state_t StPatAddr = 3'd3;
   localparam state_t StPatData = 3'd4;
   localparam state_t StEmit    = 3'd5;
   localparam state_t StNextCh  = 3'd6;

   // Note word: [5:0] pitch, [10:6] length, [14:11] instrument
   localparam int unsigned PITCH_LSB = 0;
   localparam int unsigned PITCH_W   = 6;
   localparam int unsigned LEN_LSB   = 6;
   localparam int unsigned LEN_W     = 5;
   localparam int unsigned INSTR_LSB = 11;
   localparam int unsigned INSTR_W   = 4;

   // Order word: [7:0] pattern start address, [15:8] pattern length (0 = end marker)
   localparam int unsigned PAT_ADDR_LSB = 0;
   localparam int unsigned PAT_ADDR_W   = 8;
   localparam int unsigned PAT_LEN_LSB  = 8;
   localparam int unsigned PAT_LEN_W    = 8;

endpackage

// File: rtl/seq_channel_regs.sv
// seq_channel_regs: per-channel playback position for the song sequencer.
// Holds order_idx / pat_addr / remaining for every channel. All ports address
// the channel given by ch_i.
//   clk_i, rst_i        clock, synchronous active-high reset
//   ch_i                channel selected for read, load, loop and step
//   rd_*_o              current registers of channel ch_i
//   load_en_i           load pat_addr/remaining from an order entry
//   loop_en_i           force order_idx to the loop point (end marker seen)
//   step_en_i           consume one note: pat_addr++, remaining--, maybe advance order
//   step_wrap_o         step_en_i would move order_idx from the last entry to the loop point
module seq_channel_regs #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CH_W         = 2,
   parameter int unsigned ROM_ADDR_W   = 8,
   parameter int unsigned ORDER_LEN    = 2,
   parameter int unsigned LOOP_ORDER   = 0,
   parameter int unsigned OIDX_W       = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CH_W-1:0]       ch_i,
   output logic [OIDX_W-1:0]     rd_order_idx_o,
   output logic [ROM_ADDR_W-1:0] rd_pat_addr_o,
   output logic [7:0]            rd_remaining_o,
   input  logic                  load_en_i,
   input  logic [ROM_ADDR_W-1:0] load_pat_addr_i,
   input  logic [7:0]            load_remaining_i,
   input  logic                  loop_en_i,
   input  logic                  step_en_i,
   output logic                  step_wrap_o
);

   localparam logic [OIDX_W-1:0] LastIdx = OIDX_W'(ORDER_LEN - 1);
   localparam logic [OIDX_W-1:0] LoopIdx = OIDX_W'(LOOP_ORDER);

   logic [OIDX_W-1:0]     order_idx_q [NUM_CHANNELS];
   logic [OIDX_W-1:0]     order_idx_d [NUM_CHANNELS];
   logic [ROM_ADDR_W-1:0] pat_addr_q  [NUM_CHANNELS];
   logic [ROM_ADDR_W-1:0] pat_addr_d  [NUM_CHANNELS];
   logic [7:0]            remaining_q [NUM_CHANNELS];
   logic [7:0]            remaining_d [NUM_CHANNELS];

   assign rd_order_idx_o = order_idx_q[ch_i];
   assign rd_pat_addr_o  = pat_addr_q[ch_i];
   assign rd_remaining_o = remaining_q[ch_i];

   // The pattern runs out on this step when remaining goes 1 -> 0.
   assign step_wrap_o = step_en_i && (remaining_q[ch_i] == 8'd1) &&
                        (order_idx_q[ch_i] == LastIdx);

   always_comb begin
      order_idx_d = order_idx_q;
      pat_addr_d  = pat_addr_q;
      remaining_d = remaining_q;
      if (load_en_i) begin
         pat_addr_d[ch_i]  = load_pat_addr_i;
         remaining_d[ch_i] = load_remaining_i;
      end
      if (loop_en_i) begin
         order_idx_d[ch_i] = LoopIdx;
      end
      if (step_en_i) begin
         pat_addr_d[ch_i]  = pat_addr_q[ch_i] + 1'b1;
         remaining_d[ch_i] = remaining_q[ch_i] - 8'd1;
         if (remaining_q[ch_i] == 8'd1) begin
            order_idx_d[ch_i] = (order_idx_q[ch_i] == LastIdx) ? LoopIdx
                                                               : order_idx_q[ch_i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            order_idx_q[i] <= '0;
            pat_addr_q[i]  <= '0;
            remaining_q[i] <= '0;
         end
      end else begin
         order_idx_q <= order_idx_d;
         pat_addr_q  <= pat_addr_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: rtl/multi_channel_song_sequencer.sv
// multi_channel_song_sequencer: plays a multi-channel song out of a shared
// synchronous ROM. On each row tick every channel is serviced in order and
// emits at most one note on the shared note bus.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_tick_stb          row tick (one-cycle pulse)
//   o_busy              a tick is being serviced
//   o_tick_overrun      tick arrived while busy (the tick is dropped)
//   o_song_wrap         channel 0 looped back in its order list
//   o_note_valid        note strobe; channel/pitch/len/instrument hold between strobes
//   o_rom_addr          ROM read address (0 outside the address phases)
//   i_rom_data          ROM data, one cycle after the address
module multi_channel_song_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CH_W         = 2,
   parameter int unsigned ROM_ADDR_W   = 8,
   parameter int unsigned ORDER_BASE   = 0,
   parameter int unsigned ORDER_LEN    = 2,
   parameter int unsigned LOOP_ORDER   = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_tick_stb,
   output logic                  o_busy,
   output logic                  o_tick_overrun,
   output logic                  o_song_wrap,
   output logic                  o_note_valid,
   output logic [CH_W-1:0]       o_note_channel,
   output logic [5:0]            o_note_pitch,
   output logic [4:0]            o_note_len,
   output logic [3:0]            o_note_instrument,
   output logic [ROM_ADDR_W-1:0] o_rom_addr,
   input  logic [15:0]           i_rom_data
);

   localparam int unsigned OIDX_W = (ORDER_LEN > 1) ? $clog2(ORDER_LEN) : 1;
   localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

   state_t          state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            marker_q, marker_d;  // an end marker was already seen for this channel
   logic [5:0]      pitch_q, pitch_d;
   logic [4:0]      len_q, len_d;
   logic [3:0]      instr_q, instr_d;

   logic [CH_W-1:0]       rd_ch;
   logic [OIDX_W-1:0]     rd_order_idx;
   logic [ROM_ADDR_W-1:0] rd_pat_addr;
   logic [7:0]            rd_remaining;
   logic                  load_en, loop_en, step_en, step_wrap;
   logic [ROM_ADDR_W-1:0] ord_addr, rom_addr;
   logic [7:0]            ord_len;
   state_t                chk_state;
   logic                  note_valid, song_wrap;

   // In NEXT_CH look ahead at the following channel so CHK costs no cycle.
   // In IDLE ch_q is always 0, which is the channel CHK needs there.
   always_comb begin
      rd_ch = ch_q;
      if (state_q == StNextCh && ch_q != LastCh) begin
         rd_ch = ch_q + 1'b1;
      end
   end

   seq_channel_regs #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .CH_W         (CH_W),
      .ROM_ADDR_W   (ROM_ADDR_W),
      .ORDER_LEN    (ORDER_LEN),
      .LOOP_ORDER   (LOOP_ORDER),
      .OIDX_W       (OIDX_W)
   ) u_regs (
      .clk_i            (i_clk),
      .rst_i            (i_rst),
      .ch_i             (rd_ch),
      .rd_order_idx_o   (rd_order_idx),
      .rd_pat_addr_o    (rd_pat_addr),
      .rd_remaining_o   (rd_remaining),
      .load_en_i        (load_en),
      .load_pat_addr_i  (ROM_ADDR_W'(i_rom_data[PAT_ADDR_LSB +: PAT_ADDR_W])),
      .load_remaining_i (i_rom_data[PAT_LEN_LSB +: PAT_LEN_W]),
      .loop_en_i        (loop_en),
      .step_en_i        (step_en),
      .step_wrap_o      (step_wrap)
   );

   assign ord_addr  = ROM_ADDR_W'(ORDER_BASE + 32'(ch_q) * ORDER_LEN + 32'(rd_order_idx));
   assign ord_len   = i_rom_data[PAT_LEN_LSB +: PAT_LEN_W];
   assign chk_state = (rd_remaining == 8'd0) ? StOrdAddr : StPatAddr;

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      marker_d   = marker_q;
      pitch_d    = pitch_q;
      len_d      = len_q;
      instr_d    = instr_q;
      rom_addr   = '0;
      load_en    = 1'b0;
      loop_en    = 1'b0;
      step_en    = 1'b0;
      note_valid = 1'b0;
      song_wrap  = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_tick_stb) begin
               state_d = chk_state;
            end
         end
         StOrdAddr: begin
            rom_addr = ord_addr;
            state_d  = StOrdData;
         end
         StOrdData: begin
            if (ord_len != 8'd0) begin
               load_en = 1'b1;
               state_d = StPatAddr;
            end else if (!marker_q) begin
               // First marker: restart from the loop point and refetch once.
               loop_en   = 1'b1;
               marker_d  = 1'b1;
               song_wrap = (ch_q == '0);
               state_d   = StOrdAddr;
            end else begin
               // Loop point is a marker too: channel stays silent this row.
               state_d = StNextCh;
            end
         end
         StPatAddr: begin
            rom_addr = rd_pat_addr;
            state_d  = StPatData;
         end
         StPatData: begin
            pitch_d = i_rom_data[PITCH_LSB +: PITCH_W];
            len_d   = i_rom_data[LEN_LSB +: LEN_W];
            instr_d = i_rom_data[INSTR_LSB +: INSTR_W];
            state_d = StEmit;
         end
         StEmit: begin
            note_valid = 1'b1;
            step_en    = 1'b1;
            song_wrap  = step_wrap && (ch_q == '0);
            state_d    = StNextCh;
         end
         StNextCh: begin
            marker_d = 1'b0;
            if (ch_q == LastCh) begin
               ch_d    = '0;
               state_d = StIdle;
            end else begin
               ch_d    = rd_ch;
               state_d = chk_state;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         ch_q     <= '0;
         marker_q <= 1'b0;
         pitch_q  <= '0;
         len_q    <= '0;
         instr_q  <= '0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         marker_q <= marker_d;
         pitch_q  <= pitch_d;
         len_q    <= len_d;
         instr_q  <= instr_d;
      end
   end

   assign o_busy            = (state_q != StIdle);
   assign o_tick_overrun    = i_tick_stb && (state_q != StIdle);
   assign o_song_wrap       = song_wrap;
   assign o_note_valid      = note_valid;
   assign o_note_channel    = ch_q;
   assign o_note_pitch      = pitch_q;
   assign o_note_len        = len_q;
   assign o_note_instrument = instr_q;
   assign o_rom_addr        = rom_addr;

endmodule

// File: tb/tb_multi_channel_song_sequencer.sv
// Scoreboard bench: a song-level reference model pushes expected notes, ROM
// addresses and service lengths; a negedge monitor pops and compares.
module tb_multi_channel_song_sequencer;

   localparam int NCH  = 4;
   localparam int BASE = 64;
   localparam int OL   = 3;
   localparam int LOOP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       o_busy, o_tick_overrun, o_song_wrap, o_note_valid;
   logic [1:0] o_note_channel;
   logic [5:0] o_note_pitch;
   logic [4:0] o_note_len;
   logic [3:0] o_note_instrument;
   logic [7:0] o_rom_addr;
   logic [15:0] rom_data;
   logic [15:0] rom [256];

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[o_rom_addr];

   multi_channel_song_sequencer #(
      .NUM_CHANNELS (NCH),
      .CH_W         (2),
      .ROM_ADDR_W   (8),
      .ORDER_BASE   (BASE),
      .ORDER_LEN    (OL),
      .LOOP_ORDER   (LOOP)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_tick_stb        (tick),
      .o_busy            (o_busy),
      .o_tick_overrun    (o_tick_overrun),
      .o_song_wrap       (o_song_wrap),
      .o_note_valid      (o_note_valid),
      .o_note_channel    (o_note_channel),
      .o_note_pitch      (o_note_pitch),
      .o_note_len        (o_note_len),
      .o_note_instrument (o_note_instrument),
      .o_rom_addr        (o_rom_addr),
      .i_rom_data        (rom_data)
   );

   typedef struct packed {
      logic [1:0] ch;
      logic [5:0] pitch;
      logic [4:0] len;
      logic [3:0] instr;
      logic       wrap;
   } note_t;

   note_t      note_q[$];
   logic [7:0] addr_q[$];
   int         cyc_q[$];
   int         tests_run = 0;
   int         tests_failed = 0;
   int         exp_mwraps = 0, act_mwraps = 0;
   int         exp_ovr = 0, act_ovr = 0;
   bit         mon_chk = 1'b1;
   int         busy_run = 0;
   int         m_idx[NCH];
   int         m_pat[NCH];
   int         m_rem[NCH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got an output, expected none queued", name);
   endtask

   task automatic check_zero(input string name);
      check(name, 32'({o_busy, o_tick_overrun, o_song_wrap, o_note_valid, o_note_channel,
                       o_note_pitch, o_note_len, o_note_instrument, o_rom_addr}), 32'd0);
   endtask

   // Reference model: one row of the song, straight from the playback rules.
   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_idx[c] = 0;
         m_pat[c] = 0;
         m_rem[c] = 0;
      end
   endtask

   task automatic model_tick(output int cyc);
      int    a;
      bit    silent;
      logic [15:0] e;
      logic [15:0] w;
      note_t n;
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
         silent = 1'b0;
         if (m_rem[c] == 0) begin
            a = (BASE + c * OL + m_idx[c]) % 256;
            addr_q.push_back(a[7:0]);
            e = rom[a];
            cyc += 2;
            if (e[15:8] == 8'd0) begin
               m_idx[c] = LOOP;
               if (c == 0) exp_mwraps++;
               a = (BASE + c * OL + m_idx[c]) % 256;
               addr_q.push_back(a[7:0]);
               e = rom[a];
               cyc += 2;
               if (e[15:8] == 8'd0) silent = 1'b1;
            end
            if (!silent) begin
               m_pat[c] = int'(e[7:0]);
               m_rem[c] = int'(e[15:8]);
            end
         end
         if (!silent) begin
            a = m_pat[c];
            addr_q.push_back(a[7:0]);
            w = rom[a];
            cyc += 3;
            n.ch    = c[1:0];
            n.pitch = w[5:0];
            n.len   = w[10:6];
            n.instr = w[14:11];
            n.wrap  = 1'b0;
            m_pat[c] = (m_pat[c] + 1) % 256;
            m_rem[c] = m_rem[c] - 1;
            if (m_rem[c] == 0) begin
               if (m_idx[c] == OL - 1) begin
                  m_idx[c] = LOOP;
                  n.wrap   = (c == 0);
               end else begin
                  m_idx[c] = m_idx[c] + 1;
               end
            end
            note_q.push_back(n);
         end
         cyc += 1;
      end
      cyc_q.push_back(cyc);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (o_note_valid) begin
         if (note_q.size() == 0) fail_now("note_extra");
         else check("note", 32'({o_note_channel, o_note_pitch, o_note_len, o_note_instrument,
                                 o_song_wrap}), 32'(note_q.pop_front()));
      end else if (o_song_wrap) begin
         act_mwraps++;
      end
      if (o_tick_overrun) act_ovr++;
      if (mon_chk) begin
         if (o_rom_addr != 8'd0) begin
            if (addr_q.size() == 0) fail_now("rom_addr_extra");
            else check("rom_addr", 32'(o_rom_addr), 32'(addr_q.pop_front()));
         end
         if (o_busy) begin
            busy_run++;
         end else if (busy_run > 0) begin
            if (cyc_q.size() == 0) fail_now("service_extra");
            else check("service_cycles", 32'(busy_run), 32'(cyc_q.pop_front()));
            busy_run = 0;
         end
      end else begin
         busy_run = 0;
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic tick_pulse();
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!o_busy) break;
      end
      check("service_ends", 32'(o_busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic run_tick();
      int c;
      model_tick(c);
      tick_pulse();
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_notes_left"}, 32'(note_q.size()), 32'd0);
      check({tag, "_addrs_left"}, 32'(addr_q.size()), 32'd0);
      check({tag, "_services_left"}, 32'(cyc_q.size()), 32'd0);
      check({tag, "_marker_wraps"}, 32'(act_mwraps), 32'(exp_mwraps));
      check({tag, "_overruns"}, 32'(act_ovr), 32'(exp_ovr));
   endtask

   task automatic set_directed_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      // ch0: two-note pattern, one-note pattern, end marker (loops to entry 1)
      rom[BASE + 0] = 16'h0210;
      rom[BASE + 1] = 16'h0130;
      rom[BASE + 2] = 16'h00AB;
      rom[16'h10]   = 16'h0805;
      rom[16'h11]   = 16'h0046;
      rom[16'h30]   = 16'h1FFF;
      // ch1: one note, then both the current entry and the loop entry are markers
      rom[BASE + 3] = 16'h0150;
      rom[BASE + 4] = 16'h0000;
      rom[BASE + 5] = 16'h0012;
      // ch2: three one-note patterns
      rom[BASE + 6] = 16'h0160;
      rom[BASE + 7] = 16'h0161;
      rom[BASE + 8] = 16'h0162;
      // ch3: longer patterns
      rom[BASE + 9]  = 16'h0370;
      rom[BASE + 10] = 16'h0274;
      rom[BASE + 11] = 16'h0178;
   endtask

   task automatic set_random_rom();
      int ln;
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      for (int i = 0; i < NCH * OL; i++) begin
         ln = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
         rom[BASE + i] = {8'(ln), 8'($urandom_range(8'h80, 8'hF0))};
      end
   endtask

   initial begin
      int c;
      #500000;
      $display("FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      set_directed_rom();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_zero("idle_outputs");
      end

      // Directed song: plain patterns, end marker, double marker, four channels
      for (int t = 0; t < 8; t++) run_tick();
      check_drained("directed");

      // Tick two cycles into a service
      model_tick(c);
      tick_pulse();
      @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      exp_ovr++;
      wait_idle();

      // Tick in the last NEXT_CH cycle
      model_tick(c);
      tick_pulse();
      repeat (c - 1) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      exp_ovr++;
      wait_idle();
      check_drained("overrun");

      // Reset while channel 0 is in PAT_DATA of its first service
      do_reset();
      mon_chk = 1'b0;
      tick_pulse();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_zero("mid_reset_idle");
      model_reset();
      @(negedge clk);
      check_zero("after_reset_idle");
      mon_chk = 1'b1;
      for (int t = 0; t < 3; t++) run_tick();
      check_drained("post_reset");

      // Random songs
      for (int s = 0; s < 3; s++) begin
         set_random_rom();
         do_reset();
         for (int t = 0; t < 25; t++) run_tick();
         check_drained("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
